picorv32_axi_port: RTL and testbench
====================================

# picorv32_axi_port

Native-to-AXI4-lite memory port for a picorv32 core, replacing the pass-through connection used so far between the core and its `if_axi_light` master. It accepts one native memory request at a time (`mem_valid`/`mem_ready` protocol) and drives the AXI4-lite channels itself. It adds per-node address remapping, separate AW/W handshakes, a transaction watchdog that raises `trap`, and sticky response-error reporting. It sits between each core and the interconnect, one instance per node.

## Interface
- NODE_ID, 0, node index used for address remapping.
- REMAP_EN, 1, 1 = remap local window per node; 0 = addresses pass unchanged.
- LOCAL_SIZE, 32'h0001_0000, local window size in bytes; must be a power of two and ≥ 4.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; 0 disables the watchdog.
- clk  in  1  clock; all logic rising-edge.
- res  in  1  synchronous, active-high reset.
- mem_valid  in  1  core request valid; held until `mem_ready`.
- mem_instr  in  1  request is an instruction fetch.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; 0 = read, nonzero = write.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid while `mem_ready`=1.
- m_axi_awvalid/awready/awaddr[31:0]/awprot[2:0]  AXI write-address channel (awready in).
- m_axi_wvalid/wready/wdata[31:0]/wstrb[3:0]  AXI write-data channel (wready in).
- m_axi_bvalid  in  1 / m_axi_bready  out  1 / m_axi_bresp  in  2  write-response channel.
- m_axi_arvalid/arready/araddr[31:0]/arprot[2:0]  AXI read-address channel (arready in).
- m_axi_rvalid  in  1 / m_axi_rready  out  1 / m_axi_rdata  in  32 / m_axi_rresp  in  2  read-data channel.
- trap  out  1  sticky; watchdog expired.
- err  out  1  sticky; a non-OKAY bresp or rresp was received.

## Operation
- States: IDLE, WR (AW and/or W pending), WB (await B), RA (await AR handshake), RR (await R), RESP, HALT.
- IDLE:
  - `mem_valid` with `mem_wstrb`≠0 → WR. Assert `awvalid` and `wvalid` together.
  - `mem_valid` with `mem_wstrb`=0 → RA. Assert `arvalid`.
  - Address, data, strobe and prot are registered on entry and held stable until the handshake.
- WR: the AW and W handshakes are tracked independently with done flags. Each valid drops the cycle after its own handshake. When both flags are set → WB with `bready`=1.
- WB: `bvalid` → RESP.
- RA: `arready` → RR with `rready`=1.
- RR: `rvalid` → RESP. Capture `rdata` into `mem_rdata`.
- RESP: `mem_ready`=1 for exactly one cycle, then IDLE. `mem_rdata` holds its captured value until the next read.
- Address remap: when REMAP_EN=1 and `mem_addr` < LOCAL_SIZE, AXI addr = `mem_addr` + NODE_ID×LOCAL_SIZE (32-bit wrap). Otherwise AXI addr = `mem_addr`.
- Protection: `arprot` = {`mem_instr`, 2'b00}; `awprot` = 3'b000.
- Response errors: `bresp`≠2'b00 or `rresp`≠2'b00 sets `err`. The transaction still completes normally, and read data is passed through.
- Watchdog:
  - The counter clears on leaving IDLE and increments every cycle in WR/WB/RA/RR.
  - If it reaches TIMEOUT_CYCLES before the state advances to RESP, go to HALT and set `trap`.
  - HALT: all AXI valids and readies deasserted, `mem_ready`=0, no exit except `res`.
- Reset mid-transaction: state returns to IDLE and all outputs take reset values. The downstream slave is reset together with the port.

## Timing
- Reset values: all valids/readies 0, `mem_ready`=0, `mem_rdata`=0, addrs/wdata/wstrb/prot 0, `trap`=0, `err`=0, state IDLE.
- Request latency: `mem_valid` sampled high in cycle 0 → `awvalid`/`wvalid`/`arvalid` high in cycle 1.
- With zero-wait slave:
  - Read: `arready` in cycle 1, `rvalid` in cycle 2, `mem_ready` in cycle 3.
  - Write: AW/W ready in cycle 1, `bvalid` in cycle 2, `mem_ready` in cycle 3.
- Back-to-back: a new request is accepted in the IDLE cycle after RESP (minimum 4 cycles per transaction).
- Valids never drop before their handshake except on HALT or reset.

## Test plan
- Write to 0x0002_0010 with wdata 0xA5A5_1234, wstrb 0xF; `awready` in cycle 1, `wready` in cycle 4, `bvalid` in cycle 6 → `awvalid` low from cycle 2, `wvalid` low from cycle 5, single `mem_ready` in cycle 7.
- Instruction read 0x0000_0100 with NODE_ID=2 → `araddr`=0x0002_0100, `arprot`=3'b100; `rdata`=0xDEAD_BEEF → `mem_rdata`=0xDEAD_BEEF with `mem_ready` in cycle 3.
- REMAP_EN=0, read 0x0000_0100 → `araddr`=0x0000_0100, `arprot`=3'b000 (data fetch).
- `rresp`=2'b10 on a read → `mem_ready` pulses, `err`=1 and stays 1 across 10 further OKAY transactions.
- TIMEOUT_CYCLES=16, `arready` held 0 → `trap`=1 after 16 cycles in RA, `arvalid` drops, `mem_ready` never asserts. Asserting `res` clears `trap`, and the next read completes.
- Assert `res` in WB of a write → next cycle all outputs at reset values; a following read completes in 3 cycles.

Source files
------------

// File: rtl/picorv32_axi_port_if.sv
// Native picorv32 memory bus plus AXI4-lite master channels for one core node.
// master = the port (drives AXI requests and mem responses); slave = core and interconnect side.
interface picorv32_axi_port_if;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;

   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;

   logic        m_axi_bvalid;
   logic        m_axi_bready;
   logic [1:0]  m_axi_bresp;

   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;

   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;

   modport master (
      input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata,
      output m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
      input  m_axi_awready,
      output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
      input  m_axi_wready,
      input  m_axi_bvalid, m_axi_bresp,
      output m_axi_bready,
      output m_axi_arvalid, m_axi_araddr, m_axi_arprot,
      input  m_axi_arready,
      input  m_axi_rvalid, m_axi_rdata, m_axi_rresp,
      output m_axi_rready
   );

   modport slave (
      output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata,
      input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
      output m_axi_awready,
      input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
      output m_axi_wready,
      output m_axi_bvalid, m_axi_bresp,
      input  m_axi_bready,
      input  m_axi_arvalid, m_axi_araddr, m_axi_arprot,
      output m_axi_arready,
      output m_axi_rvalid, m_axi_rdata, m_axi_rresp,
      input  m_axi_rready
   );
endinterface

// File: rtl/picorv32_axi_port.sv
// picorv32 native port to AXI4-lite master: one request in flight, AXI valids 1 cycle after request,
// zero-wait completion in 3 cycles; core is stalled until mem_ready, slave backpressure held by valids.
module picorv32_axi_port #(
   parameter int unsigned NODE_ID        = 0,
   parameter bit          REMAP_EN       = 1'b1,
   parameter logic [31:0] LOCAL_SIZE     = 32'h0001_0000,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                       clk,
   input  logic                       res,
   picorv32_axi_port_if.master        bus,
   output logic                       trap,
   output logic                       err
);
   typedef enum logic [2:0] {IDLE, WR, WB, RA, RR, RESP, HALT} state_t;

   localparam logic [31:0] NODE_BASE  = 32'(NODE_ID) * LOCAL_SIZE;
   localparam logic [31:0] WDOG_LIMIT = 32'(TIMEOUT_CYCLES);

   state_t      state;
   logic        awvalid_q;
   logic        wvalid_q;
   logic        bready_q;
   logic        arvalid_q;
   logic        rready_q;
   logic [31:0] awaddr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [31:0] araddr_q;
   logic [2:0]  arprot_q;
   logic        aw_done;
   logic        w_done;
   logic        mem_ready_q;
   logic [31:0] mem_rdata_q;
   logic [31:0] wdog_cnt;
   logic        trap_q;
   logic        err_q;

   logic [31:0] axi_addr;
   logic        aw_hs;
   logic        w_hs;
   logic        b_hs;
   logic        ar_hs;
   logic        r_hs;
   logic        busy;
   logic        to_resp;
   logic [31:0] wdog_next;
   logic        wdog_expire;

   // Only the low local window is relocated into this node's slice of the shared space.
   always_comb begin
      axi_addr = bus.mem_addr;
      if (REMAP_EN && (bus.mem_addr < LOCAL_SIZE))
         axi_addr = bus.mem_addr + NODE_BASE;
   end

   assign aw_hs = awvalid_q & bus.m_axi_awready;
   assign w_hs  = wvalid_q  & bus.m_axi_wready;
   assign b_hs  = bready_q  & bus.m_axi_bvalid;
   assign ar_hs = arvalid_q & bus.m_axi_arready;
   assign r_hs  = rready_q  & bus.m_axi_rvalid;

   assign busy    = (state == WR) || (state == WB) || (state == RA) || (state == RR);
   assign to_resp = ((state == WB) && b_hs) || ((state == RR) && r_hs);

   assign wdog_next   = wdog_cnt + 32'd1;
   assign wdog_expire = (WDOG_LIMIT != 32'd0) && (wdog_next >= WDOG_LIMIT);

   always_ff @(posedge clk) begin
      if (res) begin
         state       <= IDLE;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         araddr_q    <= '0;
         arprot_q    <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         mem_ready_q <= 1'b0;
         mem_rdata_q <= '0;
         wdog_cnt    <= '0;
         trap_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         mem_ready_q <= 1'b0;
         if (busy)
            wdog_cnt <= wdog_next;

         case (state)
            IDLE: begin
               if (bus.mem_valid) begin
                  wdog_cnt <= '0;
                  if (bus.mem_wstrb != 4'b0000) begin
                     state     <= WR;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     awaddr_q  <= axi_addr;
                     wdata_q   <= bus.mem_wdata;
                     wstrb_q   <= bus.mem_wstrb;
                     aw_done   <= 1'b0;
                     w_done    <= 1'b0;
                  end else begin
                     state     <= RA;
                     arvalid_q <= 1'b1;
                     araddr_q  <= axi_addr;
                     arprot_q  <= {bus.mem_instr, 2'b00};
                  end
               end
            end
            // AW and W complete in any order; each valid drops right after its own handshake.
            WR: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done   <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done   <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  state    <= WB;
                  bready_q <= 1'b1;
                  aw_done  <= 1'b0;
                  w_done   <= 1'b0;
               end
            end
            WB: begin
               if (b_hs) begin
                  state       <= RESP;
                  bready_q    <= 1'b0;
                  mem_ready_q <= 1'b1;
                  if (bus.m_axi_bresp != 2'b00)
                     err_q <= 1'b1;
               end
            end
            RA: begin
               if (ar_hs) begin
                  state     <= RR;
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
               end
            end
            RR: begin
               if (r_hs) begin
                  state       <= RESP;
                  rready_q    <= 1'b0;
                  mem_rdata_q <= bus.m_axi_rdata;
                  mem_ready_q <= 1'b1;
                  if (bus.m_axi_rresp != 2'b00)
                     err_q <= 1'b1;
               end
            end
            RESP:    state <= IDLE;
            HALT:    state <= HALT;
            default: state <= IDLE;
         endcase

         // Watchdog overrides whatever the state logic chose unless this cycle completes the transfer.
         if (busy && wdog_expire && !to_resp) begin
            state       <= HALT;
            trap_q      <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            mem_ready_q <= 1'b0;
         end
      end
   end

   assign bus.mem_ready     = mem_ready_q;
   assign bus.mem_rdata     = mem_rdata_q;
   assign bus.m_axi_awvalid = awvalid_q;
   assign bus.m_axi_awaddr  = awaddr_q;
   assign bus.m_axi_awprot  = 3'b000;
   assign bus.m_axi_wvalid  = wvalid_q;
   assign bus.m_axi_wdata   = wdata_q;
   assign bus.m_axi_wstrb   = wstrb_q;
   assign bus.m_axi_bready  = bready_q;
   assign bus.m_axi_arvalid = arvalid_q;
   assign bus.m_axi_araddr  = araddr_q;
   assign bus.m_axi_arprot  = arprot_q;
   assign bus.m_axi_rready  = rready_q;
   assign trap              = trap_q;
   assign err               = err_q;

   a_awvalid_hold: assert property (@(posedge clk) disable iff (res)
      (awvalid_q && !bus.m_axi_awready) |=> (awvalid_q || state == HALT));
   a_wvalid_hold: assert property (@(posedge clk) disable iff (res)
      (wvalid_q && !bus.m_axi_wready) |=> (wvalid_q || state == HALT));
   a_arvalid_hold: assert property (@(posedge clk) disable iff (res)
      (arvalid_q && !bus.m_axi_arready) |=> (arvalid_q || state == HALT));
endmodule

// File: tb/tb_picorv32_axi_port.sv
// Directed bench for picorv32_axi_port: remap, handshakes, latency, sticky err, watchdog and reset.
module tb_picorv32_axi_port;
   logic clk = 1'b0;
   logic res;
   logic trap_a, err_a, trap_b, err_b;
   int   checks   = 0;
   int   failures = 0;

   picorv32_axi_port_if bus_a();
   picorv32_axi_port_if bus_b();

   picorv32_axi_port #(
      .NODE_ID(2), .REMAP_EN(1'b1), .LOCAL_SIZE(32'h0001_0000), .TIMEOUT_CYCLES(16)
   ) dut_a (.clk(clk), .res(res), .bus(bus_a), .trap(trap_a), .err(err_a));

   picorv32_axi_port #(
      .NODE_ID(2), .REMAP_EN(1'b0), .LOCAL_SIZE(32'h0001_0000), .TIMEOUT_CYCLES(1024)
   ) dut_b (.clk(clk), .res(res), .bus(bus_b), .trap(trap_b), .err(err_b));

   always #5 clk = ~clk;

   // Per cycle 1..8 of the delayed write: stimulus {awready,wready,bvalid}, expected {awvalid,wvalid,bready,mem_ready}.
   logic [2:0] wr_stim [8] = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
   logic [3:0] wr_exp  [8] = '{4'b1100, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0001, 4'b0000};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, "_awvalid"},  32'(bus_a.m_axi_awvalid), 32'd0);
      check({tag, "_wvalid"},   32'(bus_a.m_axi_wvalid),  32'd0);
      check({tag, "_bready"},   32'(bus_a.m_axi_bready),  32'd0);
      check({tag, "_arvalid"},  32'(bus_a.m_axi_arvalid), 32'd0);
      check({tag, "_rready"},   32'(bus_a.m_axi_rready),  32'd0);
      check({tag, "_memready"}, 32'(bus_a.mem_ready),     32'd0);
      check({tag, "_memrdata"}, bus_a.mem_rdata,          32'd0);
      check({tag, "_awaddr"},   bus_a.m_axi_awaddr,       32'd0);
      check({tag, "_wdata"},    bus_a.m_axi_wdata,        32'd0);
      check({tag, "_wstrb"},    32'(bus_a.m_axi_wstrb),   32'd0);
      check({tag, "_araddr"},   bus_a.m_axi_araddr,       32'd0);
      check({tag, "_arprot"},   32'(bus_a.m_axi_arprot),  32'd0);
      check({tag, "_trap"},     32'(trap_a),              32'd0);
      check({tag, "_err"},      32'(err_a),               32'd0);
   endtask

   // Read on dut_a with a zero-wait slave; mem_ready expected in cycle 3.
   task automatic do_read(input string tag, input logic [31:0] addr, input logic instr,
                          input logic [31:0] rdata, input logic [1:0] rresp, input logic [31:0] exp_araddr);
      bus_a.mem_valid = 1'b1;
      bus_a.mem_instr = instr;
      bus_a.mem_addr  = addr;
      bus_a.mem_wstrb = 4'h0;
      tick();
      check({tag, "_arvalid"}, 32'(bus_a.m_axi_arvalid), 32'd1);
      check({tag, "_araddr"},  bus_a.m_axi_araddr, exp_araddr);
      check({tag, "_arprot"},  32'(bus_a.m_axi_arprot), instr ? 32'd4 : 32'd0);
      bus_a.m_axi_arready = 1'b1;
      tick();
      check({tag, "_rready"},  32'(bus_a.m_axi_rready), 32'd1);
      check({tag, "_rdy_c2"},  32'(bus_a.mem_ready), 32'd0);
      bus_a.m_axi_arready = 1'b0;
      bus_a.m_axi_rvalid  = 1'b1;
      bus_a.m_axi_rdata   = rdata;
      bus_a.m_axi_rresp   = rresp;
      tick();
      check({tag, "_rdy_c3"},  32'(bus_a.mem_ready), 32'd1);
      check({tag, "_rdata"},   bus_a.mem_rdata, rdata);
      bus_a.m_axi_rvalid = 1'b0;
      tick();
      check({tag, "_rdy_c4"},  32'(bus_a.mem_ready), 32'd0);
      bus_a.mem_valid = 1'b0;
      bus_a.mem_instr = 1'b0;
   endtask

   // Write on dut_a with a zero-wait slave; mem_ready expected in cycle 3.
   task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [1:0] bresp, input logic [31:0] exp_awaddr);
      bus_a.mem_valid = 1'b1;
      bus_a.mem_instr = 1'b0;
      bus_a.mem_addr  = addr;
      bus_a.mem_wdata = wdata;
      bus_a.mem_wstrb = wstrb;
      tick();
      check({tag, "_awv_wv"}, {30'd0, bus_a.m_axi_awvalid, bus_a.m_axi_wvalid}, 32'd3);
      check({tag, "_awaddr"}, bus_a.m_axi_awaddr, exp_awaddr);
      check({tag, "_wdata"},  bus_a.m_axi_wdata, wdata);
      bus_a.m_axi_awready = 1'b1;
      bus_a.m_axi_wready  = 1'b1;
      tick();
      check({tag, "_bready"}, {30'd0, bus_a.m_axi_awvalid, bus_a.m_axi_bready}, 32'd1);
      bus_a.m_axi_awready = 1'b0;
      bus_a.m_axi_wready  = 1'b0;
      bus_a.m_axi_bvalid  = 1'b1;
      bus_a.m_axi_bresp   = bresp;
      tick();
      check({tag, "_rdy_c3"}, 32'(bus_a.mem_ready), 32'd1);
      bus_a.m_axi_bvalid = 1'b0;
      tick();
      check({tag, "_rdy_c4"}, 32'(bus_a.mem_ready), 32'd0);
      bus_a.mem_valid = 1'b0;
      bus_a.mem_wstrb = 4'h0;
   endtask

   initial begin
      res = 1'b1;
      {bus_a.mem_valid, bus_a.mem_instr, bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_wstrb} = '0;
      {bus_a.m_axi_awready, bus_a.m_axi_wready, bus_a.m_axi_bvalid, bus_a.m_axi_bresp} = '0;
      {bus_a.m_axi_arready, bus_a.m_axi_rvalid, bus_a.m_axi_rdata, bus_a.m_axi_rresp} = '0;
      {bus_b.mem_valid, bus_b.mem_instr, bus_b.mem_addr, bus_b.mem_wdata, bus_b.mem_wstrb} = '0;
      {bus_b.m_axi_awready, bus_b.m_axi_wready, bus_b.m_axi_bvalid, bus_b.m_axi_bresp} = '0;
      {bus_b.m_axi_arready, bus_b.m_axi_rvalid, bus_b.m_axi_rdata, bus_b.m_axi_rresp} = '0;
      tick();
      tick();
      check_reset_a("rst");
      res = 1'b0;

      // Write with AW ready in cycle 1, W ready in cycle 4, B in cycle 6.
      bus_a.mem_valid = 1'b1;
      bus_a.mem_addr  = 32'h0002_0010;
      bus_a.mem_wdata = 32'hA5A5_1234;
      bus_a.mem_wstrb = 4'hF;
      bus_a.m_axi_bresp = 2'b00;
      for (int c = 0; c < 8; c++) begin
         tick();
         check($sformatf("dwr_c%0d", c + 1),
               {28'd0, bus_a.m_axi_awvalid, bus_a.m_axi_wvalid, bus_a.m_axi_bready, bus_a.mem_ready},
               {28'd0, wr_exp[c]});
         if (c == 0) begin
            check("dwr_awaddr", bus_a.m_axi_awaddr, 32'h0002_0010);
            check("dwr_wdata",  bus_a.m_axi_wdata,  32'hA5A5_1234);
            check("dwr_wstrb",  32'(bus_a.m_axi_wstrb), 32'hF);
            check("dwr_awprot", 32'(bus_a.m_axi_awprot), 32'd0);
         end
         {bus_a.m_axi_awready, bus_a.m_axi_wready, bus_a.m_axi_bvalid} = wr_stim[c];
         if (c == 7) begin
            bus_a.mem_valid = 1'b0;
            bus_a.mem_wstrb = 4'h0;
         end
      end

      do_read("ifetch", 32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 2'b00, 32'h0002_0100);
      do_read("win_top", 32'h0000_FFFC, 1'b0, 32'h0BAD_CAFE, 2'b00, 32'h0002_FFFC);
      check("err_clean", 32'(err_a), 32'd0);
      do_read("rresp_err", 32'h0001_0000, 1'b0, 32'h5555_AAAA, 2'b10, 32'h0001_0000);
      check("err_set", 32'(err_a), 32'd1);

      for (int i = 0; i < 10; i++) begin
         if ((i % 2) == 0)
            do_read($sformatf("ok%0d", i), 32'h0000_0200 + 32'(i * 4), 1'b0,
                    32'h1000_0000 + 32'(i), 2'b00, 32'h0002_0200 + 32'(i * 4));
         else
            do_write($sformatf("ok%0d", i), 32'h0004_0000 + 32'(i * 4), 32'h2000_0000 + 32'(i),
                     4'h3, 2'b00, 32'h0004_0000 + 32'(i * 4));
         check($sformatf("ok%0d_err_sticky", i), 32'(err_a), 32'd1);
      end

      // Reset while waiting for B.
      bus_a.mem_valid = 1'b1;
      bus_a.mem_addr  = 32'h0000_0040;
      bus_a.mem_wdata = 32'h7777_0000;
      bus_a.mem_wstrb = 4'h1;
      tick();
      check("rwb_awaddr", bus_a.m_axi_awaddr, 32'h0002_0040);
      bus_a.m_axi_awready = 1'b1;
      bus_a.m_axi_wready  = 1'b1;
      tick();
      check("rwb_in_wb", 32'(bus_a.m_axi_bready), 32'd1);
      bus_a.m_axi_awready = 1'b0;
      bus_a.m_axi_wready  = 1'b0;
      bus_a.mem_valid     = 1'b0;
      bus_a.mem_wstrb     = 4'h0;
      res = 1'b1;
      tick();
      check_reset_a("rwb");
      res = 1'b0;
      do_read("post_rst", 32'h0002_0004, 1'b0, 32'h1357_9BDF, 2'b00, 32'h0002_0004);

      do_write("bresp_err", 32'h0000_0008, 32'h0000_00FF, 4'h1, 2'b11, 32'h0002_0008);
      check("err_bresp", 32'(err_a), 32'd1);

      // Watchdog: AR never accepted.
      bus_a.mem_valid = 1'b1;
      bus_a.mem_addr  = 32'h0000_0100;
      bus_a.mem_wstrb = 4'h0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         check($sformatf("wd_c%0d", c), {30'd0, trap_a, bus_a.m_axi_arvalid}, 32'd1);
      end
      tick();
      check("wd_trap", {30'd0, trap_a, bus_a.m_axi_arvalid}, 32'd2);
      bus_a.m_axi_arready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("halt%0d", c),
               {28'd0, trap_a, bus_a.mem_ready, bus_a.m_axi_arvalid, bus_a.m_axi_rready}, 32'd8);
      end
      bus_a.m_axi_arready = 1'b0;
      bus_a.mem_valid     = 1'b0;
      res = 1'b1;
      tick();
      check("halt_rst_trap", 32'(trap_a), 32'd0);
      res = 1'b0;
      do_read("post_halt", 32'h0000_0800, 1'b0, 32'hCAFE_F00D, 2'b00, 32'h0002_0800);
      check("post_halt_trap", 32'(trap_a), 32'd0);

      // REMAP_EN=0 instance: data read passes address through.
      bus_b.mem_valid = 1'b1;
      bus_b.mem_addr  = 32'h0000_0100;
      tick();
      check("nr_araddr", bus_b.m_axi_araddr, 32'h0000_0100);
      check("nr_arprot", 32'(bus_b.m_axi_arprot), 32'd0);
      bus_b.m_axi_arready = 1'b1;
      tick();
      bus_b.m_axi_arready = 1'b0;
      bus_b.m_axi_rvalid  = 1'b1;
      bus_b.m_axi_rdata   = 32'h1234_5678;
      tick();
      check("nr_ready", 32'(bus_b.mem_ready), 32'd1);
      check("nr_rdata", bus_b.mem_rdata, 32'h1234_5678);
      bus_b.m_axi_rvalid = 1'b0;
      tick();
      bus_b.mem_valid = 1'b0;
      check("nr_status", {30'd0, trap_b, err_b}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
